m_vmem_wr_arbiter: RTL and testbench

//  Shares the single 16-bit video-memory write port (vmem, {y,x} addressing, RGB565) among NREQ pixel writers.

---
 rtl/vmem_pkg.sv | 22 ++
 rtl/m_rr_pick.sv | 31 +++
 rtl/m_vmem_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_m_vmem_wr_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared video-memory constants, FSM encodings and address/bounds helpers
// for the vmem write-port arbiter slice.
package vmem_pkg;

  localparam int VMEM_AW     = 16;
  localparam int VMEM_DW     = 16;
  localparam int SCREEN_XMAX = 239;
  localparam int SCREEN_YMAX = 239;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  function automatic logic [VMEM_AW-1:0] f_vmem_adr(input logic [7:0] y, input logic [7:0] x);
    return {y, x};
  endfunction

  function automatic logic f_in_bounds(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] xmax, input logic [7:0] ymax);
    return (x <= xmax) && (y <= ymax);
  endfunction

endpackage

// File: rtl/m_rr_pick.sv
// Combinational round-robin pick: first set request searching from
// last_grant+1 upward, wrapping modulo NREQ.
module m_rr_pick
  import vmem_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last_grant,
  output logic [2:0]      winner,
  output logic            any
);

  logic [2:0]        start_s;
  logic [2*NREQ-1:0] rot_s;
  logic [3:0]        sum_s;

  // Rotate the request vector so offset 0 is the slot after the last grant.
  always_comb begin
    start_s = (last_grant == 3'(NREQ-1)) ? 3'd0 : (last_grant + 3'd1);
    rot_s   = {req, req} >> start_s;
    winner  = start_s;
    sum_s   = 4'd0;
    for (int k = NREQ-1; k >= 0; k--) begin
      sum_s  = {1'b0, start_s} + 4'(k);
      winner = rot_s[k] ? ((sum_s >= 4'(NREQ)) ? 3'(sum_s - 4'(NREQ)) : sum_s[2:0]) : winner;
    end
    any = |req;
  end

endmodule

// File: rtl/m_vmem_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the single vmem write port.
// Optional coordinate clipping with a drop counter: VMEM_ARB_CLIP_EN.
module m_vmem_wr_arbiter
  import vmem_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 64,
  parameter int XMAX      = SCREEN_XMAX,
  parameter int YMAX      = SCREEN_YMAX
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic [NREQ-1:0]      i_valid,
  input  logic [NREQ-1:0]      i_last,
  input  logic [8*NREQ-1:0]    i_x,
  input  logic [8*NREQ-1:0]    i_y,
  input  logic [16*NREQ-1:0]   i_data,
  output logic [NREQ-1:0]      o_ready,
  output logic                 o_we,
  output logic [VMEM_AW-1:0]   o_wadr,
  output logic [VMEM_DW-1:0]   o_wdata,
  output logic [2:0]           o_grant,
`ifdef VMEM_ARB_CLIP_EN
  output logic [15:0]          o_clip_cnt,
`endif
  output logic                 o_busy
);

  logic [0:0]         state_r;
  logic [2:0]         grant_r;
  logic [7:0]         beat_cnt_r;
  logic               we_r;
  logic [VMEM_AW-1:0] wadr_r;
  logic [VMEM_DW-1:0] wdata_r;

  logic [2:0]         winner_s;
  logic               any_s;
  logic               hit_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [7:0]         sel_x_s;
  logic [7:0]         sel_y_s;
  logic [15:0]        sel_data_s;
  logic [NREQ-1:0]    ready_s;
  logic               xfer_s;
  logic               release_s;
  logic               write_s;

  m_rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (i_valid),
    .last_grant (grant_r),
    .winner     (winner_s),
    .any        (any_s)
  );

  // AND-OR select of the grant holder's beat; ready depends only on state/grant.
  always_comb begin
    hit_s       = 1'b0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_x_s     = 8'd0;
    sel_y_s     = 8'd0;
    sel_data_s  = 16'd0;
    ready_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      hit_s       = (grant_r == 3'(k));
      ready_s[k]  = (state_r == ST_LOCK) && hit_s;
      sel_valid_s = sel_valid_s | (i_valid[k] & hit_s);
      sel_last_s  = sel_last_s  | (i_last[k]  & hit_s);
      sel_x_s     = sel_x_s     | (i_x[8*k +: 8]     & {8{hit_s}});
      sel_y_s     = sel_y_s     | (i_y[8*k +: 8]     & {8{hit_s}});
      sel_data_s  = sel_data_s  | (i_data[16*k +: 16] & {16{hit_s}});
    end
    xfer_s    = (state_r == ST_LOCK) && sel_valid_s;
    release_s = sel_last_s || (beat_cnt_r == 8'(MAX_BURST-1));
  end

`ifdef VMEM_ARB_CLIP_EN
  logic        in_bounds_s;
  logic [15:0] clip_cnt_r;

  assign in_bounds_s = f_in_bounds(sel_x_s, sel_y_s, 8'(XMAX), 8'(YMAX));
  assign write_s     = xfer_s && in_bounds_s;
  assign o_clip_cnt  = clip_cnt_r;

  // Saturating count of accepted-but-dropped out-of-screen beats.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      clip_cnt_r <= 16'd0;
    end else if (xfer_s && !in_bounds_s && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end else begin
      clip_cnt_r <= clip_cnt_r;
    end
  end
`else
  assign write_s = xfer_s;
`endif

  // Arbitration FSM: one bubble in IDLE, grant locked until last or MAX_BURST.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= 3'(NREQ-1);
      beat_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            grant_r <= winner_s;
            state_r <= ST_LOCK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (xfer_s && release_s) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 8'd0;
          end else if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Registered write port; address/data hold between writes.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      we_r    <= 1'b0;
      wadr_r  <= '0;
      wdata_r <= '0;
    end else if (write_s) begin
      we_r    <= 1'b1;
      wadr_r  <= f_vmem_adr(sel_y_s, sel_x_s);
      wdata_r <= sel_data_s;
    end else begin
      we_r    <= 1'b0;
    end
  end

  assign o_ready = ready_s;
  assign o_we    = we_r;
  assign o_wadr  = wadr_r;
  assign o_wdata = wdata_r;
  assign o_grant = grant_r;
  assign o_busy  = (state_r == ST_LOCK);

endmodule

// File: tb/tb_m_vmem_wr_arbiter.sv
// Directed bench for m_vmem_wr_arbiter: a per-cycle vector table plus
// hand-written burst, forced-release, stall and clip sequences.
module tb_m_vmem_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic [3:0]  i_valid, i_last;
  logic [31:0] i_x, i_y;
  logic [63:0] i_data;
  logic [3:0]  o_ready;
  logic        o_we;
  logic [15:0] o_wadr, o_wdata;
  logic [2:0]  o_grant;
  logic        o_busy;
`ifdef VMEM_ARB_CLIP_EN
  logic [15:0] o_clip_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 w_clk = ~w_clk;

  m_vmem_wr_arbiter #(.NREQ(4), .MAX_BURST(64)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_we    (o_we),
    .o_wadr  (o_wadr),
    .o_wdata (o_wdata),
    .o_grant (o_grant),
`ifdef VMEM_ARB_CLIP_EN
    .o_clip_cnt (o_clip_cnt),
`endif
    .o_busy  (o_busy)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic [3:0]  e_ready;
    logic        e_we;
    logic [15:0] e_wadr;
    logic [15:0] e_wdata;
    logic [2:0]  e_grant;
    logic        e_busy;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic set_req(input int k, input logic v, input logic l,
                         input logic [7:0] x, input logic [7:0] y, input logic [15:0] d);
    i_valid[k]        = v;
    i_last[k]         = l;
    i_x[8*k +: 8]     = x;
    i_y[8*k +: 8]     = y;
    i_data[16*k +: 16] = d;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
  endtask

  initial begin
    //          rst   valid  last   x      y      data      | ready  we    wadr      wdata     grant busy
    tbl[0]  = '{1'b0, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0};
    tbl[3]  = '{1'b1, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h1, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'hF, 4'hF, 8'h01, 8'h02, 16'h1000, 4'h0, 1'b1, 16'h0201, 16'h1000, 3'd0, 1'b0};
    tbl[5]  = '{1'b1, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h2, 1'b0, 16'h0201, 16'h1000, 3'd1, 1'b1};
    tbl[6]  = '{1'b1, 4'hF, 4'hF, 8'h03, 8'h04, 16'h2000, 4'h0, 1'b1, 16'h0403, 16'h2001, 3'd1, 1'b0};
    tbl[7]  = '{1'b1, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h4, 1'b0, 16'h0403, 16'h2001, 3'd2, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 4'hF, 8'h05, 8'h06, 16'h3000, 4'h0, 1'b1, 16'h0605, 16'h3002, 3'd2, 1'b0};
    tbl[9]  = '{1'b1, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h8, 1'b0, 16'h0605, 16'h3002, 3'd3, 1'b1};
    tbl[10] = '{1'b1, 4'hF, 4'hF, 8'h07, 8'h08, 16'h4000, 4'h0, 1'b1, 16'h0807, 16'h4003, 3'd3, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 4'hF, 8'h00, 8'h00, 16'h0000, 4'h1, 1'b0, 16'h0807, 16'h4003, 3'd0, 1'b1};
    tbl[12] = '{1'b1, 4'hF, 4'h0, 8'h09, 8'h09, 16'h5000, 4'h1, 1'b1, 16'h0909, 16'h5000, 3'd0, 1'b1};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h1, 1'b0, 16'h0909, 16'h5000, 3'd0, 1'b1};
    tbl[14] = '{1'b1, 4'h1, 4'h1, 8'h0A, 8'h0B, 16'h6000, 4'h0, 1'b1, 16'h0B0A, 16'h6000, 3'd0, 1'b0};
    tbl[15] = '{1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0B0A, 16'h6000, 3'd0, 1'b0};
    tbl[16] = '{1'b1, 4'h9, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h8, 1'b0, 16'h0B0A, 16'h6000, 3'd3, 1'b1};
    tbl[17] = '{1'b0, 4'h8, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0};
    tbl[18] = '{1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0};

    w_rst_n = 1'b0;
    clear_all();

    // Table: reset, fairness 0,1,2,3,0 with bubbles, stall, reset mid-burst.
    for (int v = 0; v < 19; v++) begin
      w_rst_n = tbl[v].rst_n;
      for (int k = 0; k < 4; k++)
        set_req(k, tbl[v].valid[k], tbl[v].last[k], tbl[v].x, tbl[v].y, tbl[v].d | 16'(k));
      tick();
      chk($sformatf("t%0d ready", v), 32'(o_ready), 32'(tbl[v].e_ready));
      chk($sformatf("t%0d we",    v), 32'(o_we),    32'(tbl[v].e_we));
      chk($sformatf("t%0d wadr",  v), 32'(o_wadr),  32'(tbl[v].e_wadr));
      chk($sformatf("t%0d wdata", v), 32'(o_wdata), 32'(tbl[v].e_wdata));
      chk($sformatf("t%0d grant", v), 32'(o_grant), 32'(tbl[v].e_grant));
      chk($sformatf("t%0d busy",  v), 32'(o_busy),  32'(tbl[v].e_busy));
    end

    // Single 4-beat burst from requester 1.
    clear_all();
    set_req(1, 1'b1, 1'b0, 8'd0, 8'd5, 16'hF800);
    tick();
    chk("b grant", 32'(o_grant), 32'd1);
    chk("b ready", 32'(o_ready), 32'h2);
    chk("b bubble we", 32'(o_we), 32'd0);
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, (b == 3), 8'(b), 8'd5, 16'hF800);
      tick();
      chk($sformatf("b%0d we", b),    32'(o_we),    32'd1);
      chk($sformatf("b%0d wadr", b),  32'(o_wadr),  32'h0500 + 32'(b));
      chk($sformatf("b%0d wdata", b), 32'(o_wdata), 32'hF800);
      chk($sformatf("b%0d busy", b),  32'(o_busy),  32'(b != 3));
    end
    set_req(1, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    chk("b end we", 32'(o_we), 32'd0);
    chk("b hold wadr", 32'(o_wadr), 32'h0503);

    // Forced release after 64 beats; req0 then req2 again.
    set_req(2, 1'b1, 1'b0, 8'd0, 8'd20, 16'h0AA0);
    set_req(0, 1'b1, 1'b1, 8'd50, 8'd60, 16'h1234);
    tick();
    chk("f grant2", 32'(o_grant), 32'd2);
    for (int b = 0; b < 64; b++) begin
      set_req(2, 1'b1, 1'b0, 8'(b), 8'd20, 16'h0AA0);
      tick();
      chk($sformatf("f%0d we", b),   32'(o_we),   32'd1);
      chk($sformatf("f%0d wadr", b), 32'(o_wadr), 32'h1400 + 32'(b));
      chk($sformatf("f%0d busy", b), 32'(o_busy), 32'(b != 63));
    end
    tick();
    chk("f grant0", 32'(o_grant), 32'd0);
    chk("f bubble we", 32'(o_we), 32'd0);
    tick();
    chk("f req0 we", 32'(o_we), 32'd1);
    chk("f req0 wadr", 32'(o_wadr), 32'h3C32);
    chk("f req0 wdata", 32'(o_wdata), 32'h1234);
    tick();
    chk("f resume grant2", 32'(o_grant), 32'd2);
    chk("f resume busy", 32'(o_busy), 32'd1);

    // Stall: req3 holds the grant through 10 idle cycles with req0 waiting.
    set_req(0, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    set_req(2, 1'b1, 1'b1, 8'd64, 8'd20, 16'h0AA0);
    tick();
    chk("s req2 last we", 32'(o_we), 32'd1);
    set_req(2, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    set_req(3, 1'b1, 1'b0, 8'd1, 8'd1, 16'h00F0);
    set_req(0, 1'b1, 1'b0, 8'd240, 8'd10, 16'h7777);
    tick();
    chk("s grant3", 32'(o_grant), 32'd3);
    tick();
    chk("s beat1 we", 32'(o_we), 32'd1);
    set_req(3, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("s%0d busy", c),  32'(o_busy),  32'd1);
      chk($sformatf("s%0d we", c),    32'(o_we),    32'd0);
      chk($sformatf("s%0d grant", c), 32'(o_grant), 32'd3);
      chk($sformatf("s%0d ready", c), 32'(o_ready), 32'h8);
    end
    set_req(3, 1'b1, 1'b1, 8'd2, 8'd1, 16'h00F1);
    tick();
    chk("s resume we", 32'(o_we), 32'd1);
    chk("s resume wadr", 32'(o_wadr), 32'h0102);
    chk("s resume busy", 32'(o_busy), 32'd0);
    set_req(3, 1'b0, 1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    chk("s next grant0", 32'(o_grant), 32'd0);

    // Out-of-screen beat from req0: dropped with clipping, written without.
`ifdef VMEM_ARB_CLIP_EN
    chk("c cnt0", 32'(o_clip_cnt), 32'd0);
    tick();
    chk("c drop we", 32'(o_we), 32'd0);
    chk("c cnt1", 32'(o_clip_cnt), 32'd1);
    chk("c still busy", 32'(o_busy), 32'd1);
    set_req(0, 1'b1, 1'b1, 8'd239, 8'd239, 16'hABCD);
    tick();
    chk("c edge we", 32'(o_we), 32'd1);
    chk("c edge wadr", 32'(o_wadr), 32'hEFEF);
    chk("c edge wdata", 32'(o_wdata), 32'hABCD);
    chk("c edge busy", 32'(o_busy), 32'd0);
`else
    set_req(0, 1'b1, 1'b1, 8'd240, 8'd10, 16'h7777);
    tick();
    chk("c noclip we", 32'(o_we), 32'd1);
    chk("c noclip wadr", 32'(o_wadr), 32'h0AF0);
    chk("c noclip busy", 32'(o_busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
